// File: rtl/bus_fabric_pkg.sv
// Shared types and constants for the 6502 SoC bus fabric: FSM states,
// counter and index widths, and the standard memory map
// (RAM, BASIC, video, GPIO, ACIA, Wishbone, ROM).
package bus_fabric_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } bf_state_e;

    // Wait-state counter width and region index width (NREG is at most 16)
    localparam int WAIT_W    = 4;
    localparam int REG_IDX_W = 4;

    localparam int BF_NREG = 7;
    localparam int BF_AW   = 16;

    // Region i occupies bits [i*16 +: 16]; region 0 is the rightmost entry
    localparam logic [BF_NREG*BF_AW-1:0] BF_DEF_BASE = {
        16'hF800, 16'hF100, 16'hF000, 16'hDC00, 16'hD000, 16'hA000, 16'h0000
    };
    localparam logic [BF_NREG*BF_AW-1:0] BF_DEF_MASK = {
        16'hF800, 16'hFF00, 16'hFF00, 16'hFC00, 16'hFC00, 16'hE000, 16'h8000
    };
    localparam logic [BF_NREG*WAIT_W-1:0] BF_DEF_WAIT = '0;

endpackage

// File: rtl/bus_fabric_decode.sv
// Combinational fixed-priority address decoder: region i hits when
// (ab & MASK_i) == BASE_i, and the lowest hitting index wins.
module bus_fabric_decode
    import bus_fabric_pkg::*;
#(
    parameter int                 NREG = BF_NREG,
    parameter int                 AW   = BF_AW,
    parameter logic [NREG*AW-1:0] BASE = BF_DEF_BASE,
    parameter logic [NREG*AW-1:0] MASK = BF_DEF_MASK
) (
    input  logic [AW-1:0]        ab_i,
    output logic [NREG-1:0]      sel_o,
    output logic [REG_IDX_W-1:0] idx_o,
    output logic                 hit_o
);

    // Scan from the top down so the lowest hitting region is the last writer
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((ab_i & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
                hit_o = 1'b1;
                idx_o = REG_IDX_W'(i);
            end
        end
        sel_o = '0;
        for (int i = 0; i < NREG; i++) begin
            sel_o[i] = hit_o && (idx_o == REG_IDX_W'(i));
        end
    end

endmodule

// File: rtl/bus_fabric.sv
// Address decode, read-return mux and ready generation for the 6502 SoC.
// Optional sticky unmapped-access flag enabled by defining BUS_FABRIC_ERR_EN.
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int                     NREG        = BF_NREG,
    parameter int                     AW          = BF_AW,
    parameter int                     DW          = 8,
    parameter logic [NREG*AW-1:0]     BASE        = BF_DEF_BASE,
    parameter logic [NREG*AW-1:0]     MASK        = BF_DEF_MASK,
    parameter logic [NREG*WAIT_W-1:0] WAIT        = BF_DEF_WAIT,
    parameter int                     DEFAULT_REG = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AW-1:0]        cpu_ab,
    input  logic                 cpu_we,
    input  logic [NREG*DW-1:0]   slv_do,
    input  logic [NREG-1:0]      slv_rdy,
    output logic [NREG-1:0]      sel,
    output logic [DW-1:0]        cpu_di,
    output logic                 cpu_rdy,
    output logic                 err,
    output logic [AW-1:0]        err_addr,
    input  logic                 err_clr
);

    localparam logic [NREG-1:0]   MUX_RST = NREG'(1) << DEFAULT_REG;
    localparam logic [WAIT_W-1:0] CNT_ONE = WAIT_W'(1);

    logic [REG_IDX_W-1:0] idx;
    logic                 hit;
    bf_state_e            state_q, state_d;
    logic [WAIT_W-1:0]    cnt_q, cnt_d;
    logic [REG_IDX_W-1:0] reg_q, reg_d;
    logic [NREG-1:0]      mux_q;
    logic [WAIT_W-1:0]    wait_n;
    logic                 hit_rdy;
    logic                 held_rdy;
    logic                 rdy_c;

    // Slaves see cpu_we directly; the fabric only routes selects
    logic unused_we;
    assign unused_we = cpu_we;

    bus_fabric_decode #(
        .NREG (NREG),
        .AW   (AW),
        .BASE (BASE),
        .MASK (MASK)
    ) u_decode (
        .ab_i  (cpu_ab),
        .sel_o (sel),
        .idx_o (idx),
        .hit_o (hit)
    );

    // Per-region lookups: wait count and ready of the live decode and of the held region
    always_comb begin
        wait_n   = '0;
        hit_rdy  = 1'b0;
        held_rdy = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (sel[i]) begin
                wait_n  = WAIT[i*WAIT_W +: WAIT_W];
                hit_rdy = slv_rdy[i];
            end
            if (reg_q == REG_IDX_W'(i)) begin
                held_rdy = slv_rdy[i];
            end
        end
    end

    // Wait FSM next state and ready; unmapped accesses complete immediately
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        reg_d   = reg_q;
        rdy_c   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    if (wait_n == '0) begin
                        rdy_c = hit_rdy;
                    end else begin
                        rdy_c   = 1'b0;
                        cnt_d   = wait_n - CNT_ONE;
                        reg_d   = idx;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    rdy_c = 1'b0;
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    rdy_c = held_rdy;
                    if (held_rdy) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cpu_rdy = reset | rdy_c;

    // FSM state, counter, held region and read-mux select registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            reg_q   <= '0;
            mux_q   <= MUX_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            reg_q   <= reg_d;
            if (cpu_rdy) begin
                mux_q <= sel;
            end
        end
    end

    // Read-return mux; an empty select falls back to the default region
    always_comb begin
        cpu_di = slv_do[DEFAULT_REG*DW +: DW];
        for (int i = 0; i < NREG; i++) begin
            if (mux_q[i]) begin
                cpu_di = slv_do[i*DW +: DW];
            end
        end
    end

`ifdef BUS_FABRIC_ERR_EN
    logic          err_q, err_d;
    logic [AW-1:0] err_addr_q, err_addr_d;

    // Sticky error: a new unmapped access outranks a simultaneous clear
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if ((state_q == ST_IDLE) && !hit && (!err_q || err_clr)) begin
            err_d      = 1'b1;
            err_addr_d = cpu_ab;
        end
    end

    // Error flag and captured address registers
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;
`else
    logic unused_clr;
    assign unused_clr = err_clr;
    assign err        = 1'b0;
    assign err_addr   = '0;
`endif

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: a default-map instance with waits on
// regions 3 and 4, and an 8-region instance with an overlapping region 7.
module tb_bus_fabric;
    import bus_fabric_pkg::*;

`ifdef BUS_FABRIC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: 7 regions, WAIT_3 = 3, WAIT_4 = 5
    logic [15:0] ab_a;
    logic        we_a, clr_a, rdy_a, err_a;
    logic [55:0] slv_do_a;
    logic [6:0]  slv_rdy_a, sel_a;
    logic [7:0]  di_a;
    logic [15:0] erra_a;

    // Instance B: 8 regions, region 7 overlaps region 0, WAIT_3 = 2
    logic [15:0] ab_b;
    logic        we_b, clr_b, rdy_b, err_b;
    logic [63:0] slv_do_b;
    logic [7:0]  slv_rdy_b, sel_b;
    logic [7:0]  di_b;
    logic [15:0] erra_b;

    bus_fabric #(
        .NREG (7), .AW (16), .DW (8),
        .BASE (BF_DEF_BASE), .MASK (BF_DEF_MASK),
        .WAIT (28'h0053000), .DEFAULT_REG (6)
    ) dut_a (
        .clk (clk), .reset (reset), .cpu_ab (ab_a), .cpu_we (we_a),
        .slv_do (slv_do_a), .slv_rdy (slv_rdy_a), .sel (sel_a),
        .cpu_di (di_a), .cpu_rdy (rdy_a), .err (err_a),
        .err_addr (erra_a), .err_clr (clr_a)
    );

    bus_fabric #(
        .NREG (8), .AW (16), .DW (8),
        .BASE ({16'h0000, BF_DEF_BASE}), .MASK ({16'hF000, BF_DEF_MASK}),
        .WAIT (32'h0000_2000), .DEFAULT_REG (6)
    ) dut_b (
        .clk (clk), .reset (reset), .cpu_ab (ab_b), .cpu_we (we_b),
        .slv_do (slv_do_b), .slv_rdy (slv_rdy_b), .sel (sel_b),
        .cpu_di (di_b), .cpu_rdy (rdy_b), .err (err_b),
        .err_addr (erra_b), .err_clr (clr_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] ab;
        logic [6:0]  srdy;
        logic [6:0]  sel;
        logic        rdy;
        int          rgn;
    } vec_t;

    vec_t       vecs[14];
    logic [7:0] sb[$];

    function automatic logic [7:0] pat(input int i);
        return 8'h5A + 8'(i) * 8'h11;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] last;
        logic [7:0] exp;
        int         low;
        logic       sel_ok;

        for (int i = 0; i < 7; i++) slv_do_a[i*8 +: 8] = pat(i);
        for (int i = 0; i < 8; i++) slv_do_b[i*8 +: 8] = pat(i);
        slv_rdy_a = '1; slv_rdy_b = '1;
        we_a = 1'b0; we_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        ab_b = 16'h0000;

        vecs[0]  = '{16'h1234, 7'h7F, 7'b0000001, 1'b1, 0};
        vecs[1]  = '{16'h7FFF, 7'h7F, 7'b0000001, 1'b1, 0};
        vecs[2]  = '{16'hA000, 7'h7F, 7'b0000010, 1'b1, 1};
        vecs[3]  = '{16'hBFFF, 7'h7F, 7'b0000010, 1'b1, 1};
        vecs[4]  = '{16'hD3FF, 7'h7F, 7'b0000100, 1'b1, 2};
        vecs[5]  = '{16'hF100, 7'h7F, 7'b0100000, 1'b1, 5};
        vecs[6]  = '{16'hF7FF, 7'h7F, 7'b0000000, 1'b1, 6};
        vecs[7]  = '{16'hF800, 7'h7F, 7'b1000000, 1'b1, 6};
        vecs[8]  = '{16'hFFFF, 7'h7F, 7'b1000000, 1'b1, 6};
        vecs[9]  = '{16'h8000, 7'h7F, 7'b0000000, 1'b1, 6};
        vecs[10] = '{16'hA555, 7'h7D, 7'b0000010, 1'b0, 1};
        vecs[11] = '{16'h0000, 7'h7F, 7'b0000001, 1'b1, 0};
        vecs[12] = '{16'hD000, 7'h7B, 7'b0000100, 1'b0, 2};
        vecs[13] = '{16'hE000, 7'h00, 7'b0000000, 1'b1, 6};

        // Reset: ready forced high even on a wait-region address
        reset = 1'b1;
        ab_a  = 16'hDC00;
        step();
        @(negedge clk);
        chk("rst_rdy", 32'(rdy_a), 32'd1);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_err_addr", 32'(erra_a), 32'd0);
        chk("rst_di_default", 32'(di_a), 32'(pat(6)));
        step();

        // Table of single-cycle accesses with a read-data scoreboard
        reset = 1'b0;
        last  = pat(6);
        sb.push_back(last);
        for (int k = 0; k < 14; k++) begin
            ab_a      = vecs[k].ab;
            slv_rdy_a = vecs[k].srdy;
            @(negedge clk);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                chk($sformatf("vec%0d_di", k), 32'(di_a), 32'(exp));
            end
            chk($sformatf("vec%0d_sel", k), 32'(sel_a), 32'(vecs[k].sel));
            chk($sformatf("vec%0d_rdy", k), 32'(rdy_a), 32'(vecs[k].rdy));
            if (vecs[k].rdy) last = pat(vecs[k].rgn);
            sb.push_back(last);
            step();
        end
        slv_rdy_a = '1;
        ab_a      = 16'h1234;
        @(negedge clk);
        exp = sb.pop_front();
        chk("vec_tail_di", 32'(di_a), 32'(exp));
        step();

        // WAIT_3 = 3 on 0xDC00: three low cycles, then ready
        ab_a   = 16'hDC00;
        low    = 0;
        sel_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sel_a !== 7'b0001000) sel_ok = 1'b0;
            if (rdy_a === 1'b1) break;
            low++;
            step();
        end
        chk("wait3_low_cycles", 32'(low), 32'd3);
        chk("wait3_sel_held", 32'(sel_ok), 32'd1);
        step();
        ab_a = 16'h1234;
        @(negedge clk);
        chk("wait3_di", 32'(di_a), 32'(pat(3)));
        step();

        // Overlap on instance B: region 0 outranks region 7
        ab_b = 16'h0100;
        @(negedge clk);
        chk("overlap_sel", 32'(sel_b), 32'h01);
        chk("overlap_rdy", 32'(rdy_b), 32'd1);
        step();

        // WAIT_3 = 2 with slv_rdy[3] low for 4 cycles after expiry: 6 low
        ab_b = 16'hDC00;
        low  = 0;
        for (int k = 0; k < 20; k++) begin
            slv_rdy_b[3] = (k >= 2 && k <= 5) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (rdy_b === 1'b1) break;
            low++;
            step();
        end
        chk("stall_low_cycles", 32'(low), 32'd6);
        step();
        slv_rdy_b = '1;
        ab_b      = 16'h0100;
        @(negedge clk);
        chk("stall_di", 32'(di_b), 32'(pat(3)));
        step();

        // Reset during the 2nd wait cycle of a WAIT = 5 access
        ab_a = 16'hF000;
        @(negedge clk);
        chk("w5_first_low", 32'(rdy_a), 32'd0);
        step();
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("w5_rdy_in_reset", 32'(rdy_a), 32'd1);
        step();
        reset = 1'b0;
        ab_a  = 16'h1234;
        @(negedge clk);
        chk("w5_rdy_after_reset", 32'(rdy_a), 32'd1);
        chk("w5_di_default", 32'(di_a), 32'(pat(6)));
        step();
        ab_a = 16'hF000;
        low  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rdy_a === 1'b1) break;
            low++;
            step();
        end
        chk("w5_low_cycles", 32'(low), 32'd5);
        step();

        // Unmapped-access error flag sequence
        reset = 1'b1;
        ab_a  = 16'h1234;
        step();
        reset = 1'b0;
        ab_a  = 16'hC000;
        @(negedge clk);
        chk("err_c000_sel", 32'(sel_a), 32'd0);
        chk("err_c000_rdy", 32'(rdy_a), 32'd1);
        step();
        ab_a = 16'hE000;
        @(negedge clk);
        chk("err_set", 32'(err_a), 32'(ERR_EN));
        chk("err_addr_c000", 32'(erra_a), ERR_EN ? 32'hC000 : 32'h0);
        chk("err_di_rom", 32'(di_a), 32'(pat(6)));
        step();
        ab_a = 16'h1234;
        @(negedge clk);
        chk("err_addr_kept", 32'(erra_a), ERR_EN ? 32'hC000 : 32'h0);
        chk("err_still_set", 32'(err_a), 32'(ERR_EN));
        step();
        ab_a  = 16'hE000;
        clr_a = 1'b1;
        @(negedge clk);
        chk("err_before_clr_edge", 32'(err_a), 32'(ERR_EN));
        step();
        clr_a = 1'b0;
        ab_a  = 16'h1234;
        @(negedge clk);
        chk("err_clr_collide", 32'(err_a), 32'(ERR_EN));
        chk("err_addr_e000", 32'(erra_a), ERR_EN ? 32'hE000 : 32'h0);
        step();
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        @(negedge clk);
        chk("err_cleared", 32'(err_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
